// File: rtl/draw_manager.sv
// draw_manager: consumer of the shared draw-source write bus.
// Each frame it grants the bus to every source in turn, collects the pixel
// stream, writes opaque in-range pixels into the back framebuffer bank,
// then swaps banks.
// Optional build macro: DRAW_MANAGER_CLEAR_EN -- when defined, each frame
// starts by filling the back bank with CLEAR_COLOR before any source runs.
module draw_manager #(
  parameter int SOURCE_COUNT      = 4,
  parameter int SOURCE_SEL_ADDRW  = 2,
  parameter int DRAW_WIDTH        = 160,
  parameter int DRAW_HEIGHT       = 120,
  parameter int DRAW_WIDTH_ADDRW  = 8,
  parameter int DRAW_HEIGHT_ADDRW = 7,
  parameter int COLOR_DEPTH       = 9,
  parameter int FB_ADDRW          = 15,
  parameter int AWAIT_TIMEOUT     = 1023,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic                         write_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic                         fb_bank,
  output logic [FB_ADDRW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0]       fb_wdata,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   skip_count
);

  // Timeout counter runs 0..AWAIT_TIMEOUT-1, giving exactly AWAIT_TIMEOUT
  // cycles in AWAIT before a silent source is skipped.
  localparam int TO_W = (AWAIT_TIMEOUT > 1) ? $clog2(AWAIT_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AWAIT_TIMEOUT - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SEL = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
  localparam logic [31:0] W32 = 32'(DRAW_WIDTH);
  localparam logic [31:0] H32 = 32'(DRAW_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GRANT  = 3'd2,
    S_AWAIT  = 3'd3,
    S_STREAM = 3'd4,
    S_NEXT   = 3'd5,
    S_SWAP   = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [SOURCE_SEL_ADDRW-1:0]   sel_q, sel_d;
  logic                          awaited_q, awaited_d;
  logic                          busy_q, busy_d;
  logic                          bank_q, bank_d;
  logic [7:0]                    skip_q, skip_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic                          fb_we_q, fb_we_d;
  logic [FB_ADDRW-1:0]           fb_addr_q, fb_addr_d;
  logic [COLOR_DEPTH-1:0]        fb_wdata_q, fb_wdata_d;

`ifdef DRAW_MANAGER_CLEAR_EN
  localparam logic [FB_ADDRW-1:0] CLR_LAST = FB_ADDRW'(DRAW_WIDTH * DRAW_HEIGHT - 1);
  logic [FB_ADDRW-1:0]           clr_q, clr_d;
`else
  // Background colour only matters when the clear pass is built in.
  logic                          unused_clear_color;
  assign unused_clear_color = ^CLEAR_COLOR;
`endif

  // Pixel decode: a sample is taken only while the granted source owns the
  // bus; only opaque, in-range pixels turn into a framebuffer write.
  logic        pix_sample;
  logic        pix_ok;
  logic [31:0] pix_addr_full;

  // Decode the incoming pixel into a write candidate.
  always_comb begin
    pix_sample    = write_active && ((state_q == S_AWAIT) || (state_q == S_STREAM));
    pix_addr_full = 32'(write_y_addr) * W32 + 32'(write_x_addr);
    pix_ok        = pix_sample && !write_transparent &&
                    (32'(write_x_addr) < W32) && (32'(write_y_addr) < H32);
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    awaited_d  = awaited_q;
    busy_d     = busy_q;
    bank_d     = bank_q;
    skip_d     = skip_q;
    to_cnt_d   = to_cnt_q;
    fb_we_d    = pix_ok;
    fb_addr_d  = pix_ok ? FB_ADDRW'(pix_addr_full) : fb_addr_q;
    fb_wdata_d = pix_ok ? write_color_data : fb_wdata_q;
`ifdef DRAW_MANAGER_CLEAR_EN
    clr_d      = clr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (frame) begin
          sel_d  = '0;
          busy_d = 1'b1;
`ifdef DRAW_MANAGER_CLEAR_EN
          clr_d   = '0;
          state_d = S_CLEAR;
`else
          state_d = S_GRANT;
`endif
        end
      end

`ifdef DRAW_MANAGER_CLEAR_EN
      // One background write per cycle across the whole back bank.
      S_CLEAR: begin
        fb_we_d    = 1'b1;
        fb_addr_d  = clr_q;
        fb_wdata_d = CLEAR_COLOR;
        if (clr_q == CLR_LAST) begin
          state_d = S_GRANT;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
`endif

      S_GRANT: begin
        awaited_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = S_AWAIT;
      end

      // First pixel (if any) is consumed by pix_ok in this same cycle.
      S_AWAIT: begin
        if (write_active) begin
          state_d = S_STREAM;
        end else if (to_cnt_q == TO_LAST) begin
          awaited_d = 1'b0;
          if (skip_q != 8'hFF) skip_d = skip_q + 8'd1;
          state_d = S_NEXT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_STREAM: begin
        if (!write_active) begin
          awaited_d = 1'b0;
          state_d   = S_NEXT;
        end
      end

      // Bank flips on entry to SWAP; the last pixel's write has already
      // been presented at least one cycle earlier on the old bank.
      S_NEXT: begin
        if (sel_q == LAST_SEL) begin
          bank_d  = ~bank_q;
          state_d = S_SWAP;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = S_GRANT;
        end
      end

      S_SWAP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      awaited_q  <= 1'b0;
      busy_q     <= 1'b0;
      bank_q     <= 1'b0;
      skip_q     <= '0;
      to_cnt_q   <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      awaited_q  <= awaited_d;
      busy_q     <= busy_d;
      bank_q     <= bank_d;
      skip_q     <= skip_d;
      to_cnt_q   <= to_cnt_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

`ifdef DRAW_MANAGER_CLEAR_EN
  // Clear-pass address counter.
  always_ff @(posedge clk) begin
    if (rst) clr_q <= '0;
    else     clr_q <= clr_d;
  end
`endif

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign fb_we            = fb_we_q;
  assign fb_bank          = bank_q;
  assign fb_addr          = fb_addr_q;
  assign fb_wdata         = fb_wdata_q;
  assign busy             = busy_q;
  assign frame_done       = (state_q == S_SWAP);
  assign skip_count       = skip_q;

endmodule

// File: tb/tb_draw_manager.sv
// Scoreboard bench for draw_manager: the driver plays all draw sources and
// pushes expected framebuffer writes / bank swaps; a monitor pops and
// compares whenever the DUT writes or signals frame_done.
module tb_draw_manager;
  localparam int NS = 4;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame = 1'b0;
  logic [1:0] write_source_sel;
  logic       write_awaited;
  logic       write_active = 1'b0;
  logic [8:0] write_color_data = '0;
  logic       write_transparent = 1'b0;
  logic [7:0] write_x_addr = '0;
  logic [6:0] write_y_addr = '0;
  logic       fb_we, fb_bank, busy, frame_done;
  logic [14:0] fb_addr;
  logic [8:0] fb_wdata;
  logic [7:0] skip_count;

  draw_manager dut (
    .clk(clk), .rst(rst), .frame(frame),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_color_data(write_color_data),
    .write_transparent(write_transparent), .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_bank(fb_bank),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .busy(busy),
    .frame_done(frame_done), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [8:0]  data;
    logic        bank;
    int          cyc;
  } wr_t;

  wr_t  exp_q[$];
  logic done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic exp_bank = 1'b0;
  int   exp_skip = 0;

  int         px_n[NS];
  logic [7:0] px_x[NS][8];
  logic [6:0] px_y[NS][8];
  logic [8:0] px_c[NS][8];
  logic       px_t[NS][8];
  bit         skip_src[NS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write and every swap must match the head of its queue.
  initial begin
    wr_t  e;
    logic b;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (fb_we) begin
          if (exp_q.size() == 0) chk("spurious_write", 32'(fb_we), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(fb_addr), 32'(e.addr));
            chk("wr_data", 32'(fb_wdata), 32'(e.data));
            chk("wr_bank", 32'(fb_bank), 32'(e.bank));
            chk("wr_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        if (frame_done) begin
          if (done_q.size() == 0) chk("spurious_frame_done", 32'(frame_done), 32'd0);
          else begin
            b = done_q.pop_front();
            chk("swap_bank", 32'(fb_bank), 32'(b));
          end
        end
      end
    end
  end

  // Reference rule: opaque and inside the draw area -> write at y*W+x.
  function automatic void model_pixel(input int s, input int k);
    int a;
    if (!px_t[s][k] && int'(px_x[s][k]) < W && int'(px_y[s][k]) < H) begin
      a = int'(px_y[s][k]) * W + int'(px_x[s][k]);
      exp_q.push_back('{addr: a[14:0], data: px_c[s][k], bank: exp_bank, cyc: cyc + 1});
    end
  endfunction

  task automatic pulse_frame(input bit expect_start);
    frame = 1'b1;
`ifdef DRAW_MANAGER_CLEAR_EN
    if (expect_start)
      for (int i = 0; i < W * H; i++)
        exp_q.push_back('{addr: 15'(i), data: 9'h000, bank: exp_bank, cyc: cyc + 2 + i});
`else
    if (expect_start) chk("frame_accept_idle", 32'(busy), 32'd0);
`endif
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic wait_awaited(input logic lvl, input int limit);
    int n;
    n = 0;
    while (write_awaited !== lvl && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) chk("wait_awaited_timeout", 32'(write_awaited), 32'(lvl));
  endtask

  task automatic rand_sources();
    for (int s = 0; s < NS; s++) begin
      skip_src[s] = 1'b0;
      px_n[s] = $urandom_range(1, 5);
      for (int k = 0; k < 8; k++) begin
        px_x[s][k] = 8'($urandom_range(0, 170));
        px_y[s][k] = 7'($urandom_range(0, 127));
        px_c[s][k] = 9'($urandom);
        px_t[s][k] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic set_px(input int s, input int k, input int x, input int y, input int c, input bit t);
    px_x[s][k] = 8'(x); px_y[s][k] = 7'(y); px_c[s][k] = 9'(c); px_t[s][k] = t;
  endtask

  // Idle bus noise: write_active outside a grant must be ignored.
  task automatic idle_gap();
    repeat ($urandom_range(2, 5)) begin
      write_active = 1'($urandom); write_x_addr = 8'($urandom_range(0, 150));
      write_y_addr = 7'($urandom_range(0, 100)); write_transparent = 1'b0;
      write_color_data = 9'($urandom);
      @(negedge clk);
    end
    write_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic stream_source(input int s);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int k = 0; k < px_n[s]; k++) begin
      write_active = 1'b1;
      write_x_addr = px_x[s][k]; write_y_addr = px_y[s][k];
      write_color_data = px_c[s][k]; write_transparent = px_t[s][k];
      model_pixel(s, k);
      @(negedge clk);
    end
    write_active = 1'b0;
    write_x_addr = 8'($urandom); write_color_data = 9'($urandom);
    @(negedge clk);
    chk("awaited_drop", 32'(write_awaited), 32'd0);
  endtask

  task automatic run_frame(input bit pulse_busy);
    int n;
    pulse_frame(1'b1);
    for (int s = 0; s < NS; s++) begin
      wait_awaited(1'b1, 25000);
      chk("grant_sel", 32'(write_source_sel), 32'(s));
      if (pulse_busy && s == 1) pulse_frame(1'b0);
      if (skip_src[s]) begin
        n = 0;
        while (write_awaited === 1'b1 && n < TIMEOUT + 50) begin n++; @(negedge clk); end
        chk("await_cycles", 32'(n), 32'(TIMEOUT));
        if (exp_skip < 255) exp_skip++;
        chk("skip_count", 32'(skip_count), 32'(exp_skip));
      end else begin
        stream_source(s);
      end
    end
    done_q.push_back(~exp_bank);
    exp_bank = ~exp_bank;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("frame_end_busy", 32'(busy), 32'd0);
    chk("bank_after_frame", 32'(fb_bank), 32'(exp_bank));
    if (pulse_busy) begin
      n = 0;
      repeat (5) begin @(negedge clk); if (busy !== 1'b0) n++; end
      chk("busy_pulse_ignored", 32'(n), 32'd0);
    end
  endtask

  initial begin
    int n;
    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(write_source_sel), 0);
    chk("rst_awaited", 32'(write_awaited), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_bank", 32'(fb_bank), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_wdata", 32'(fb_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_skip", 32'(skip_count), 0);
    n = 0;
    repeat (100) begin @(negedge clk); if (fb_we || busy || frame_done) n++; end
    chk("idle_quiet", 32'(n), 0);

    // Directed frame: corner pixels from source 0, one pixel from the rest.
    rand_sources();
    px_n[0] = 3;
    set_px(0, 0, 0, 0, 'h1FF, 0);
    set_px(0, 1, 159, 119, 'h1FF, 0);
    set_px(0, 2, 10, 2, 'h1FF, 0);
    for (int s = 1; s < NS; s++) begin
      px_n[s] = 1;
      set_px(s, 0, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom, 0);
    end
    run_frame(1'b0);
    idle_gap();

    // Transparent and out-of-range pixels must never write.
    rand_sources();
    px_n[0] = 4;
    set_px(0, 0, 5, 5, 'h0AA, 1);
    set_px(0, 1, 160, 0, 'h155, 0);
    set_px(0, 2, 0, 120, 'h0F0, 0);
    set_px(0, 3, 255, 127, 'h00F, 0);
    run_frame(1'b0);
    idle_gap();

    // Random frames.
    repeat (6) begin
      rand_sources();
      run_frame(1'b0);
      idle_gap();
    end

    // Silent source 2 is skipped on timeout; the frame still swaps.
    rand_sources();
    skip_src[2] = 1'b1;
    run_frame(1'b0);
    idle_gap();

    // A frame pulse while busy is ignored.
    rand_sources();
    run_frame(1'b1);
    idle_gap();

    // Reset in the middle of a stream abandons the frame with no swap.
    rand_sources();
    pulse_frame(1'b1);
    wait_awaited(1'b1, 25000);
    pulse_frame(1'b0);
    for (int k = 0; k < 2; k++) begin
      write_active = 1'b1; write_transparent = 1'b0;
      write_x_addr = 8'($urandom_range(0, W - 1)); write_y_addr = 7'($urandom_range(0, H - 1));
      write_color_data = 9'($urandom);
      px_x[0][k] = write_x_addr; px_y[0][k] = write_y_addr;
      px_c[0][k] = write_color_data; px_t[0][k] = 1'b0;
      model_pixel(0, k);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_active = 1'b0;
    exp_bank = 1'b0;
    exp_skip = 0;
    chk("midrst_sel", 32'(write_source_sel), 0);
    chk("midrst_awaited", 32'(write_awaited), 0);
    chk("midrst_bank", 32'(fb_bank), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_skip", 32'(skip_count), 0);
    n = 0;
    repeat (10) begin @(negedge clk); if (frame_done || busy || fb_we) n++; end
    chk("midrst_quiet", 32'(n), 0);

    // Recovery frame after reset.
    rand_sources();
    run_frame(1'b0);
    repeat (4) @(negedge clk);

    chk("exp_writes_drained", 32'(exp_q.size()), 0);
    chk("exp_swaps_drained", 32'(done_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute safety net so the run always ends.
  initial begin
    #20000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
